pnb_spi_frame_rx: RTL and testbench
===================================

PNB_SPI_FRAME_RX -- requirements
Module: pnb_spi_frame_rx

Interface
REQ-001 Parameter DATA_W, default 16, SHALL set the word width in bits (legal range 2..32).
REQ-002 Parameter SYNC_STAGES, default 2, SHALL set the synchronizer depth for sck and cs_n (legal range 2..3).
REQ-003 clk  input  1  SHALL be the single system clock; all state changes on its rising edge.
REQ-004 rst_n  input  1  SHALL be the asynchronous, active-low reset.
REQ-005 sck  input  1  SHALL be the serial clock from the SPI transmit stage; asynchronous to clk.
REQ-006 sdo  input  1  SHALL be the serial data from the SPI transmit stage, MSB first, stable around sck rising edges.
REQ-007 cs_n  input  1  SHALL be the active-low frame enable; asynchronous to clk.
REQ-008 data_out  output  DATA_W  SHALL carry the last complete received word.
REQ-009 data_vld  output  1  SHALL be a one-clk pulse marking a new word on data_out.
REQ-010 frame_err  output  1  SHALL be a one-clk pulse marking a malformed frame.
REQ-011 busy  output  1  SHALL be high whenever the state is not IDLE.

Function
REQ-012 sck, sdo and cs_n SHALL each pass through a SYNC_STAGES-deep flop chain before use; sdo SHALL be sampled from its synchronized copy.
REQ-013 A sck rising edge SHALL be detected as synchronized sck = 1 with previous synchronized sck = 0; a cs_n rise likewise.
REQ-014 The state machine SHALL have three states: IDLE, SHIFT, HOLD.
REQ-015 IDLE -> SHIFT when synchronized cs_n = 0; bit counter cleared and extra flag cleared on entry.
REQ-016 In SHIFT, each detected sck edge SHALL shift synchronized sdo into the shift register LSB (left shift) and increment the bit counter.
REQ-017 On the detected edge that brings the bit count to DATA_W, data_out SHALL load the completed word and data_vld SHALL pulse high in the next clk cycle, for exactly one cycle; state -> HOLD.
REQ-018 data_out SHALL hold its value between words and SHALL NOT change on frame_err.
REQ-019 In SHIFT, a detected cs_n rise before DATA_W bits SHALL discard the partial word, pulse frame_err for one cycle, and go to IDLE.
REQ-020 In HOLD, detected sck edges SHALL be ignored for data and SHALL set the extra flag.
REQ-021 In HOLD, a detected cs_n rise SHALL go to IDLE and pulse frame_err for one cycle if the extra flag is set.
REQ-022 If the final sck edge and the cs_n rise are detected in the same clk cycle in SHIFT, the bit SHALL be taken first: the word is valid, data_vld pulses, no frame_err, state -> IDLE.
REQ-023 The bit counter SHALL be ceil(log2(DATA_W+1)) bits wide and SHALL NOT wrap; counting stops at DATA_W.
REQ-024 Back-to-back frames (cs_n high for at least SYNC_STAGES+1 clks between frames) SHALL each produce their own data_vld.
REQ-025 Correct capture is required only when sck high and low phases each last at least SYNC_STAGES+1 clk periods; faster sck is out of scope.

Reset
REQ-026 While rst_n = 0: state IDLE; data_out, data_vld, frame_err, busy, shift register, counter, extra flag = 0; sck sync chain = 0; cs_n sync chain = 1.
REQ-027 Reset asserted mid-frame SHALL abort the frame immediately without any data_vld or frame_err pulse; after release, a frame in progress SHALL NOT be captured until cs_n has returned high and then low again.

Verification
REQ-028 DATA_W=16, clk 100 MHz, sck 5 MHz, frame 0xA5C3 -> data_out = 0xA5C3, one data_vld pulse, frame_err never high, busy low after cs_n rise.
REQ-029 Frame of 7 bits then cs_n rise -> frame_err single pulse, no data_vld, data_out keeps the previous value.
REQ-030 Frame of 18 bits (first 16 = 0x1234) -> data_vld with 0x1234 after bit 16, frame_err pulse at cs_n rise.
REQ-031 Two consecutive frames 0xFFFF, 0x0001 with 4-clk cs_n gap -> two data_vld pulses with the correct values in order.
REQ-032 rst_n low after bit 9 of frame 0xBEEF, released while cs_n still low -> no outputs for that frame; next full frame 0x5A5A -> data_out = 0x5A5A.
REQ-033 Last sck edge and cs_n rise arriving in the same synchronized cycle for frame 0x8001 -> data_vld with 0x8001, no frame_err.

Source files
------------

// File: rtl/pnb_spi_frame_rx_if.sv
// SPI receive-side bus: serial inputs from the transmit stage and the
// word/status outputs handed to the consumer.
interface pnb_spi_frame_rx_if #(
    parameter int DATA_W = 16
);
    logic              sck;
    logic              sdo;
    logic              cs_n;
    logic [DATA_W-1:0] data_out;
    logic              data_vld;
    logic              frame_err;
    logic              busy;

    modport master (
        output sck, sdo, cs_n,
        input  data_out, data_vld, frame_err, busy
    );

    modport slave (
        input  sck, sdo, cs_n,
        output data_out, data_vld, frame_err, busy
    );
endinterface

// File: rtl/pnb_spi_frame_rx.sv
// Oversampling SPI frame receiver: synchronizes sck/sdo/cs_n into clk,
// assembles DATA_W-bit MSB-first words and flags short or over-long frames.
module pnb_spi_frame_rx #(
    parameter int DATA_W      = 16,
    parameter int SYNC_STAGES = 2
) (
    input  logic               clk,
    input  logic               rst_n,
    pnb_spi_frame_rx_if.slave  bus
);
    localparam int CNT_W = $clog2(DATA_W + 1);

    typedef enum logic [1:0] {IDLE, SHIFT, HOLD} state_e;

    logic [SYNC_STAGES-1:0] sck_sync_q, sdo_sync_q, cs_sync_q, flush_q;
    logic                   sck_prev_q, cs_prev_q;
    logic                   sck_s, sdo_s, cs_s, sck_rise, cs_rise, last_bit;

    state_e                 state_q;
    logic [DATA_W-1:0]      shift_q, data_q, word_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic                   extra_q, armed_q, vld_q, err_q, busy_q;

    // flush_q marks when the chain outputs reflect real pins rather than
    // reset values, so cs_n idle-high after reset can arm the receiver.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sck_sync_q <= '0;
            sdo_sync_q <= '0;
            cs_sync_q  <= '1;
            flush_q    <= '0;
            sck_prev_q <= 1'b0;
            cs_prev_q  <= 1'b1;
        end else begin
            // NOTE: non-blocking so each stage captures the previous stage's old value.
            sck_sync_q <= {sck_sync_q[SYNC_STAGES-2:0], bus.sck};
            sdo_sync_q <= {sdo_sync_q[SYNC_STAGES-2:0], bus.sdo};
            cs_sync_q  <= {cs_sync_q[SYNC_STAGES-2:0], bus.cs_n};
            flush_q    <= {flush_q[SYNC_STAGES-2:0], 1'b1};
            sck_prev_q <= sck_sync_q[SYNC_STAGES-1];
            cs_prev_q  <= cs_sync_q[SYNC_STAGES-1];
        end
    end

    assign sck_s    = sck_sync_q[SYNC_STAGES-1];
    assign sdo_s    = sdo_sync_q[SYNC_STAGES-1];
    assign cs_s     = cs_sync_q[SYNC_STAGES-1];
    assign sck_rise = sck_s & ~sck_prev_q;
    assign cs_rise  = cs_s & ~cs_prev_q;
    assign word_d   = {shift_q[DATA_W-2:0], sdo_s};
    assign cnt_d    = cnt_q + CNT_W'(1);
    assign last_bit = sck_rise && (cnt_q == CNT_W'(DATA_W - 1));

    // A frame already in progress at reset release is skipped: armed_q only
    // sets once cs_n is seen high through a flushed synchronizer.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            shift_q <= '0;
            data_q  <= '0;
            cnt_q   <= '0;
            extra_q <= 1'b0;
            armed_q <= 1'b0;
            vld_q   <= 1'b0;
            err_q   <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            vld_q <= 1'b0;
            err_q <= 1'b0;
            if (flush_q[SYNC_STAGES-1] && cs_s) armed_q <= 1'b1;

            case (state_q)
                IDLE: begin
                    if (armed_q && !cs_s) begin
                        state_q <= SHIFT;
                        busy_q  <= 1'b1;
                        shift_q <= '0;
                        cnt_q   <= '0;
                        extra_q <= 1'b0;
                    end
                end
                SHIFT: begin
                    if (sck_rise) begin
                        shift_q <= word_d;
                        cnt_q   <= cnt_d;
                    end
                    // The final bit wins over a coincident cs_n rise.
                    if (last_bit) begin
                        data_q  <= word_d;
                        vld_q   <= 1'b1;
                        state_q <= cs_rise ? IDLE : HOLD;
                        busy_q  <= ~cs_rise;
                    end else if (cs_rise) begin
                        err_q   <= 1'b1;
                        state_q <= IDLE;
                        busy_q  <= 1'b0;
                    end
                end
                HOLD: begin
                    if (sck_rise) extra_q <= 1'b1;
                    if (cs_rise) begin
                        err_q   <= extra_q | sck_rise;
                        state_q <= IDLE;
                        busy_q  <= 1'b0;
                    end
                end
                default: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.data_out  = data_q;
    assign bus.data_vld  = vld_q;
    assign bus.frame_err = err_q;
    assign bus.busy      = busy_q;
endmodule

// File: tb/tb_pnb_spi_frame_rx.sv
// Scoreboard bench for pnb_spi_frame_rx: directed frames push expected
// word/error events, a negedge monitor pops and compares each DUT pulse.
module tb_pnb_spi_frame_rx;
    localparam int DATA_W = 16;
    localparam int HALF   = 10;   // sck half period in clk cycles (5 MHz at 100 MHz)

    typedef struct packed {
        logic              is_err;
        logic [DATA_W-1:0] data;
    } exp_t;

    logic clk;
    logic rst_n;
    int   checks;
    int   errors;
    exp_t exp_q[$];
    exp_t mon_e;

    pnb_spi_frame_rx_if #(.DATA_W(DATA_W)) ifc ();

    pnb_spi_frame_rx #(.DATA_W(DATA_W), .SYNC_STAGES(2)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (ifc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic wait_clks(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic push(input logic is_err, input logic [DATA_W-1:0] data);
        exp_t e;
        e.is_err = is_err;
        e.data   = data;
        exp_q.push_back(e);
    endtask

    // Monitor: every output pulse must match the oldest expected event.
    always @(negedge clk) begin
        if (rst_n && (ifc.data_vld || ifc.frame_err)) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_output: vld=%0b err=%0b data_out=%h",
                         ifc.data_vld, ifc.frame_err, ifc.data_out);
            end else begin
                mon_e = exp_q.pop_front();
                if ({ifc.frame_err, ifc.data_vld, ifc.data_out} !==
                    {mon_e.is_err, ~mon_e.is_err, mon_e.data}) begin
                    errors++;
                    $display("FAIL scoreboard: got err=%0b vld=%0b data=%h expected err=%0b vld=%0b data=%h",
                             ifc.frame_err, ifc.data_vld, ifc.data_out,
                             mon_e.is_err, ~mon_e.is_err, mon_e.data);
                end
            end
        end
    end

    // Shifts bits[n-1:0] MSB first; optionally raises cs_n with the last sck rise.
    task automatic shift_bits(input logic [31:0] bits, input int n, input bit cs_with_last);
        for (int i = n - 1; i >= 0; i--) begin
            ifc.sdo = bits[i];
            wait_clks(HALF);
            ifc.sck = 1'b1;
            if (i == 0 && cs_with_last) ifc.cs_n = 1'b1;
            wait_clks(HALF);
            ifc.sck = 1'b0;
        end
    endtask

    task automatic frame(input logic [31:0] bits, input int n, input bit cs_with_last, input int gap);
        ifc.cs_n = 1'b0;
        wait_clks(HALF);
        check("busy_in_frame", {31'b0, ifc.busy}, 32'd1);
        shift_bits(bits, n, cs_with_last);
        if (!cs_with_last) begin
            wait_clks(HALF);
            ifc.cs_n = 1'b1;
        end
        wait_clks(gap);
    endtask

    initial begin
        checks   = 0;
        errors   = 0;
        rst_n    = 1'b0;
        ifc.sck  = 1'b0;
        ifc.sdo  = 1'b0;
        ifc.cs_n = 1'b1;
        wait_clks(4);
        check("rst_data_out", {16'b0, ifc.data_out}, 32'h0);
        check("rst_data_vld", {31'b0, ifc.data_vld}, 32'h0);
        check("rst_frame_err", {31'b0, ifc.frame_err}, 32'h0);
        check("rst_busy", {31'b0, ifc.busy}, 32'h0);
        rst_n = 1'b1;
        wait_clks(5);

        // Nominal frame.
        push(1'b0, 16'hA5C3);
        frame(32'hA5C3, 16, 1'b0, 20);
        check("busy_after_a5c3", {31'b0, ifc.busy}, 32'h0);
        check("data_a5c3", {16'b0, ifc.data_out}, 32'hA5C3);

        // Short frame: error, data_out unchanged.
        push(1'b1, 16'hA5C3);
        frame(32'h55, 7, 1'b0, 20);
        check("data_after_short", {16'b0, ifc.data_out}, 32'hA5C3);

        // Over-long frame: word after bit 16, error at cs_n rise.
        push(1'b0, 16'h1234);
        push(1'b1, 16'h1234);
        frame((32'h1234 << 2) | 32'h2, 18, 1'b0, 20);
        check("busy_after_long", {31'b0, ifc.busy}, 32'h0);

        // Back-to-back frames with a 4-clk cs_n gap.
        push(1'b0, 16'hFFFF);
        frame(32'hFFFF, 16, 1'b0, 4);
        push(1'b0, 16'h0001);
        frame(32'h0001, 16, 1'b0, 20);
        check("data_b2b", {16'b0, ifc.data_out}, 32'h0001);

        // Reset after 9 bits; rest of that frame must be ignored.
        ifc.cs_n = 1'b0;
        wait_clks(HALF);
        shift_bits(32'hBEEF >> 7, 9, 1'b0);
        rst_n = 1'b0;
        wait_clks(3);
        check("midrst_data_out", {16'b0, ifc.data_out}, 32'h0);
        check("midrst_busy", {31'b0, ifc.busy}, 32'h0);
        rst_n = 1'b1;
        shift_bits(32'hBEEF & 32'h7F, 7, 1'b0);
        wait_clks(HALF);
        check("no_capture_after_rst", {31'b0, ifc.busy}, 32'h0);
        ifc.cs_n = 1'b1;
        wait_clks(HALF);
        check("data_after_aborted", {16'b0, ifc.data_out}, 32'h0);
        push(1'b0, 16'h5A5A);
        frame(32'h5A5A, 16, 1'b0, 20);
        check("data_5a5a", {16'b0, ifc.data_out}, 32'h5A5A);

        // Last sck rise and cs_n rise together: word valid, no error.
        push(1'b0, 16'h8001);
        frame(32'h8001, 16, 1'b1, 20);
        check("busy_after_simul", {31'b0, ifc.busy}, 32'h0);

        wait_clks(20);
        check("scoreboard_drained", exp_q.size(), 32'd0);
        check("final_data_out", {16'b0, ifc.data_out}, 32'h8001);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
